// File: rtl/rf_write_arbiter.sv
// Round-robin owner of the RF1 write port with same-cycle read bypass; writes issue 1 cycle after the handshake,
// and a requester that loses the contest holds its request until granted. RF_SCRUB_EN adds the post-reset x1..x31 scrub.
module rf_write_arbiter #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 5,
    parameter int                NUM_REGS    = 32,
    parameter logic [DATA_W-1:0] SCRUB_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              init_busy
);

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              rr_last_q, rr_last_d;
    logic              run;
    logic              grant0, grant1;

`ifdef RF_SCRUB_EN
    typedef enum logic {ST_SCRUB, ST_RUN} state_t;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    assign run       = (state_q == ST_RUN);
    assign init_busy = (state_q == ST_SCRUB);
`else
    // Scrub-only parameters have no consumer in this build.
    logic unused_scrub_cfg;
    assign unused_scrub_cfg = ^{SCRUB_VALUE, 32'(NUM_REGS)};
    assign run              = 1'b1;
    assign init_busy        = 1'b0;
`endif

    // rr_last names the previous winner, so the other requester wins a tie.
    assign grant0 = run & req0_valid & (~req1_valid | rr_last_q);
    assign grant1 = run & req1_valid & (~req0_valid | ~rr_last_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        rr_last_d    = rr_last_q;
`ifdef RF_SCRUB_EN
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (state_q == ST_SCRUB) begin
            reg_write_d  = 1'b1;
            write_reg_d  = cnt_q;
            write_data_d = SCRUB_VALUE;
            if (cnt_q == LAST_REG) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
`endif
        // x0 writes complete the handshake but never raise the enable.
        if (grant0) begin
            reg_write_d  = |req0_addr;
            write_reg_d  = req0_addr;
            write_data_d = req0_data;
            rr_last_d    = 1'b0;
        end else if (grant1) begin
            reg_write_d  = |req1_addr;
            write_reg_d  = req1_addr;
            write_data_d = req1_data;
            rr_last_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            rr_last_q    <= 1'b1;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            rr_last_q    <= rr_last_d;
        end
    end

`ifdef RF_SCRUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCRUB;
            cnt_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign RegWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;

    assign readData1 = (reg_write_q && (write_reg_q == readReg1) && (write_reg_q != '0)) ? write_data_q : rf_rdata1;
    assign readData2 = (reg_write_q && (write_reg_q == readReg2) && (write_reg_q != '0)) ? write_data_q : rf_rdata2;

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the 64-bit, 32-entry register file (RF1).
- Shares that port between two writeback requesters (req0 = ALU result, req1 = load result) using valid/ready handshakes and round-robin arbitration.
- Provides same-cycle write-to-read bypass on both RF read ports.
- Can optionally clear the register file after reset before normal operation begins.

Parameters:
DATA_W, 64, register data width
ADDR_W, 5, register address width
NUM_REGS, 32, register count; x0 is hardwired zero
SCRUB_VALUE, 0, value written to every register during scrub

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a write pending
req0_addr  in  ADDR_W  requester 0 destination register
req0_data  in  DATA_W  requester 0 write data
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid  in  1  requester 1 has a write pending
req1_addr  in  ADDR_W  requester 1 destination register
req1_data  in  DATA_W  requester 1 write data
req1_ready  out  1  requester 1 write accepted this cycle
RegWrite  out  1  RF write enable (registered)
writeReg  out  ADDR_W  RF write address (registered)
writeData  out  DATA_W  RF write data (registered)
readReg1  in  ADDR_W  RF read address 1 (passthrough, for bypass compare)
readReg2  in  ADDR_W  RF read address 2
rf_rdata1  in  DATA_W  raw RF readData1
rf_rdata2  in  DATA_W  raw RF readData2
readData1  out  DATA_W  bypassed read data 1
readData2  out  DATA_W  bypassed read data 2
init_busy  out  1  scrub in progress; no grants while high

Behaviour:
- Reset (rst_n=0, asynchronous):
  - RegWrite=0, writeReg=0, writeData=0, rr_last=1 (req0 wins the first contest), state=SCRUB if RF_SCRUB_EN is defined else RUN, scrub counter=1.
  - init_busy follows the state.
- States: SCRUB, RUN.
- SCRUB:
  - reqX_ready=0.
  - Each rising edge registers RegWrite=1, writeReg=cnt, writeData=SCRUB_VALUE, then cnt++.
  - At the edge that issues cnt=NUM_REGS-1, state moves to RUN.
  - Writes x1..x31 occur on edges 1..31 after reset release; x0 is never written.
  - init_busy=(state==SCRUB), so it drops at edge 31.
- RUN arbitration (combinational ready, state==RUN only):
  - One valid: that requester gets ready=1.
  - Both valid: the requester that was not rr_last gets ready; the other sees ready=0 and must hold valid, addr and data stable.
  - A handshake is valid&&ready, sampled at the rising edge.
  - rr_last is updated to the granted index on every grant, contested or not.
  - At most one ready is high in any cycle.
- Write issue:
  - Latency is 1 cycle. At a handshake edge N, writeReg/writeData load the granted addr/data, and RegWrite=1 if addr!=0, else 0.
  - RF captures the write at edge N+1.
  - With no handshake, RegWrite is 0 at the next edge; writeReg/writeData hold their values.
- x0 writes are accepted (ready=1, handshake completes) but suppressed: RegWrite=0, and x0 still consumes the grant and updates rr_last.
- Bypass (combinational): readDataK = writeData when RegWrite && writeReg==readRegK && writeReg!=0, else rf_rdataK. Bypass is active during SCRUB as well.
- Back-to-back: one write per cycle sustained; both requesters continuously valid alternate 0,1,0,1.
- Reset mid-scrub or mid-write: all registers return to reset values immediately; any in-flight RegWrite is dropped; scrub restarts at x1.
- All unsigned; no arithmetic beyond the counter increment; the counter never exceeds NUM_REGS-1.

Optional Feature:
RF_SCRUB_EN
- Defined: the SCRUB state exists; 31 zeroing writes happen after every reset; init_busy=1 until edge 31.
- Undefined: the SCRUB state and counter are not built; state is RUN from reset; init_busy is tied 0; grants are possible in the first cycle after rst_n rises.

Test Plan:
- Scrub (RF_SCRUB_EN): release reset -> RegWrite=1 on edges 1..31 with writeReg=1..31 and writeData=0; init_busy 1→0 at edge 31; reqX_ready=0 throughout the scrub.
- Single requester: req0_valid=1, addr=3, data=5 in RUN -> req0_ready=1; next edge RegWrite=1, writeReg=3, writeData=5; the following edge RegWrite=0.
- Contention: both valid for 4 cycles (req0 addr=1/data=0xA, req1 addr=2/data=0xB) -> grants alternate 0,1,0,1 starting with req0 after reset; the losing requester's ready stays 0 that cycle.
- x0 write: req1_valid=1, addr=0, data=0xFF -> req1_ready=1; RegWrite stays 0; no bypass on readReg1=0.
- Bypass: RegWrite=1, writeReg=3, writeData=5, readReg1=3, rf_rdata1=0 -> readData1=5; readReg2=1 -> readData2=rf_rdata2.
- Reset mid-operation: assert rst_n=0 while RegWrite=1 -> RegWrite=0 immediately; after release, scrub restarts at writeReg=1 (or idles in RUN without RF_SCRUB_EN).
